// File: rtl/button_seq_pkg.sv
// Shared state and direction encodings for the button sequence driver.
// The abort feature of the driver is enabled by defining BUTTON_SEQ_ABORT_EN.
package button_seq_pkg;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_PRESS = 2'd1;
    localparam logic [1:0] ST_GAP   = 2'd2;
    localparam logic [1:0] ST_DONE  = 2'd3;

    typedef enum logic [1:0] {
        IDLE  = ST_IDLE,
        PRESS = ST_PRESS,
        GAP   = ST_GAP,
        DONE  = ST_DONE
    } state_t;

    localparam logic DIR_UP   = 1'b1;
    localparam logic DIR_DOWN = 1'b0;

endpackage

// File: rtl/button_seq_timer.sv
// Loadable down-counter with terminal-count flag; times both the button hold
// and the post-release gap.
module button_seq_timer
    import button_seq_pkg::*;
#(
    parameter int TW = 8
) (
    input  logic          clk,
    input  logic          rst_neg,
    input  logic          load_i,
    input  logic [TW-1:0] load_val_i,
    output logic          tc_o
);

    logic [TW-1:0] count_q, count_d;

    // Saturates at zero so tc stays asserted until the next load.
    always_comb begin
        count_d = count_q;
        if (load_i) begin
            count_d = load_val_i;
        end else if (count_q != '0) begin
            count_d = count_q - 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_neg) begin
        if (!rst_neg) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign tc_o = (count_q == '0);

endmodule

// File: rtl/button_seq_driver.sv
// Steps a downstream up/down button counter to a requested target along the
// shortest modular path. Define BUTTON_SEQ_ABORT_EN to add abort/aborted.
module button_seq_driver
    import button_seq_pkg::*;
#(
    parameter int N           = 4,
    parameter int HOLD_CYCLES = 4,
    parameter int GAP_CYCLES  = 4,
    parameter int TW          = 8
) (
    input  logic         clk,
    input  logic         rst_neg,
    // start is taken only on a cycle where ready is high; the request then
    // runs to completion and finishes with a single done pulse.
    input  logic         start,
    input  logic [N-1:0] target,
`ifdef BUTTON_SEQ_ABORT_EN
    input  logic         abort,
    output logic         aborted,
`endif
    output logic         ready,
    output logic         done,
    output logic         but_up,
    output logic         but_down,
    output logic [N-1:0] cur_count,
    output state_t       dbg_state
);

    localparam logic [TW-1:0] HOLD_LOAD = TW'(HOLD_CYCLES - 1);
    localparam logic [TW-1:0] GAP_LOAD  = TW'(GAP_CYCLES - 1);
    localparam logic [N-1:0]  HALF      = N'(2 ** (N - 1));

    state_t        state_q, state_d;
    logic [N-1:0]  tgt_q, tgt_d;
    logic [N-1:0]  cnt_q, cnt_d;
    logic [N-1:0]  diff;
    logic          dir_q, dir_d;
    logic          ready_q, done_q, up_q, down_q;
    logic          tmr_load;
    logic [TW-1:0] tmr_val;
    logic          tmr_tc;

`ifdef BUTTON_SEQ_ABORT_EN
    logic abort_req;
    logic aborted_q;
    assign abort_req = abort;
`else
    localparam logic abort_req = 1'b0;
`endif

    button_seq_timer #(.TW(TW)) u_timer (
        .clk        (clk),
        .rst_neg    (rst_neg),
        .load_i     (tmr_load),
        .load_val_i (tmr_val),
        .tc_o       (tmr_tc)
    );

    assign diff = target - cnt_q;

    always_comb begin
        state_d  = state_q;
        tgt_d    = tgt_q;
        cnt_d    = cnt_q;
        dir_d    = dir_q;
        tmr_load = 1'b0;
        tmr_val  = HOLD_LOAD;
        case (state_q)
            IDLE: begin
                if (start) begin
                    tgt_d = target;
                    if (diff == '0) begin
                        state_d = DONE;
                    end else begin
                        // Exactly half-way round is resolved upwards.
                        dir_d    = (diff <= HALF) ? DIR_UP : DIR_DOWN;
                        state_d  = PRESS;
                        tmr_load = 1'b1;
                        tmr_val  = HOLD_LOAD;
                    end
                end
            end
            PRESS: begin
                if (tmr_tc || abort_req) begin
                    // Shadow count moves on release, like the downstream counter.
                    cnt_d    = (dir_q == DIR_UP) ? cnt_q + 1'b1 : cnt_q - 1'b1;
                    state_d  = abort_req ? DONE : GAP;
                    tmr_load = 1'b1;
                    tmr_val  = GAP_LOAD;
                end
            end
            GAP: begin
                if (abort_req) begin
                    state_d = DONE;
                end else if (tmr_tc) begin
                    if (cnt_q == tgt_q) begin
                        state_d = DONE;
                    end else begin
                        state_d  = PRESS;
                        tmr_load = 1'b1;
                        tmr_val  = HOLD_LOAD;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_neg) begin
        if (!rst_neg) begin
            state_q <= IDLE;
            tgt_q   <= '0;
            cnt_q   <= '0;
            dir_q   <= DIR_UP;
            ready_q <= 1'b1;
            done_q  <= 1'b0;
            up_q    <= 1'b0;
            down_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            tgt_q   <= tgt_d;
            cnt_q   <= cnt_d;
            dir_q   <= dir_d;
            ready_q <= (state_d == IDLE);
            done_q  <= (state_d == DONE);
            up_q    <= (state_d == PRESS) && (dir_d == DIR_UP);
            down_q  <= (state_d == PRESS) && (dir_d == DIR_DOWN);
        end
    end

`ifdef BUTTON_SEQ_ABORT_EN
    always_ff @(posedge clk or negedge rst_neg) begin
        if (!rst_neg) begin
            aborted_q <= 1'b0;
        end else begin
            aborted_q <= abort_req && ((state_q == PRESS) || (state_q == GAP));
        end
    end
    assign aborted = aborted_q;
`endif

    assign ready     = ready_q;
    assign done      = done_q;
    assign but_up    = up_q;
    assign but_down  = down_q;
    assign cur_count = cnt_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_button_seq_driver.sv
// Bench for button_seq_driver with N=4, HOLD=2, GAP=3 and a release-counting
// model of the downstream counter.
module tb_button_seq_driver;
    import button_seq_pkg::*;

    localparam int HOLD = 2;
    localparam int GAP  = 3;
    localparam int PER  = HOLD + GAP;

    logic       clk = 1'b0;
    logic       rst_neg = 1'b0;
    logic       start = 1'b0;
    logic [3:0] target = 4'd0;
    logic       ready, done, but_up, but_down;
    logic [3:0] cur_count;
    state_t     dbg_state;
`ifdef BUTTON_SEQ_ABORT_EN
    logic       abort = 1'b0;
    logic       aborted;
`endif

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int done_cnt = 0;
    logic chk_len = 1'b1;

    // {done cycle[16], up pulses[8], down pulses[8], cur_count[4], downstream[4], aborted[1]}
    logic [40:0] exp_q[$];
    logic [40:0] e;

    logic       prev_up = 1'b0, prev_dn = 1'b0;
    int         hi_len = 0, up_cnt = 0, dn_cnt = 0;
    logic [3:0] ds_cnt = 4'd0;

    button_seq_driver #(
        .N(4), .HOLD_CYCLES(HOLD), .GAP_CYCLES(GAP), .TW(8)
    ) dut (
        .clk       (clk),
        .rst_neg   (rst_neg),
        .start     (start),
        .target    (target),
`ifdef BUTTON_SEQ_ABORT_EN
        .abort     (abort),
        .aborted   (aborted),
`endif
        .ready     (ready),
        .done      (done),
        .but_up    (but_up),
        .but_down  (but_down),
        .cur_count (cur_count),
        .dbg_state (dbg_state)
    );

    // clock / cycle counter
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // monitor + downstream counter model + scoreboard
    always @(negedge clk) begin
        if (!rst_neg) begin
            prev_up = 1'b0; prev_dn = 1'b0; hi_len = 0;
            up_cnt = 0; dn_cnt = 0; ds_cnt = 4'd0;
        end else begin
            check("buttons_exclusive", {31'd0, but_up & but_down}, 32'd0);
            if (prev_up && !but_up) ds_cnt = ds_cnt + 4'd1;
            if (prev_dn && !but_down) ds_cnt = ds_cnt - 4'd1;
            if (but_up && !prev_up) up_cnt++;
            if (but_down && !prev_dn) dn_cnt++;
            if (but_up || but_down) begin
                hi_len++;
            end else if (hi_len != 0) begin
                if (chk_len) check("hold_len", hi_len, HOLD);
                hi_len = 0;
            end
            if (done) begin
                if (exp_q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL unexpected_done: got done=1 expected no pending request (cycle %0d)", cyc);
                end else begin
                    e = exp_q.pop_front();
                    check("done_cycle", 32'(cyc), {16'd0, e[40:25]});
                    check("up_pulses", up_cnt, {24'd0, e[24:17]});
                    check("down_pulses", dn_cnt, {24'd0, e[16:9]});
                    check("cur_count", {28'd0, cur_count}, {28'd0, e[8:5]});
                    check("downstream_count", {28'd0, ds_cnt}, {28'd0, e[4:1]});
                    check("ready_at_done", {31'd0, ready}, 32'd0);
`ifdef BUTTON_SEQ_ABORT_EN
                    check("aborted", {31'd0, aborted}, {31'd0, e[0]});
`endif
                end
                up_cnt = 0; dn_cnt = 0;
                done_cnt++;
            end
            prev_up = but_up; prev_dn = but_down;
        end
    end

    // driver tasks
    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic issue(input logic [3:0] tgt, input int off, input int nup, input int ndn,
                         input logic [3:0] exp_cur, input logic ab, output int t);
        int n = 0;
        while (!ready && n < 100) begin step(); n++; end
        if (!ready) begin
            checks++; errors++;
            $display("FAIL ready_timeout: got ready=0 expected 1 within 100 cycles");
        end
        start = 1'b1;
        target = tgt;
        t = cyc + 1;
        exp_q.push_back({16'(t + off), 8'(nup), 8'(ndn), exp_cur, exp_cur, ab});
        step();
        start = 1'b0;
        target = ~tgt;
    endtask

    task automatic wait_done(input int want);
        int n = 0;
        while (done_cnt < want && n < 200) begin step(); n++; end
        if (done_cnt < want) begin
            checks++; errors++;
            $display("FAIL done_timeout: got %0d done pulses expected %0d", done_cnt, want);
        end
    endtask

    initial begin
        int t;
        rst_neg = 1'b0;
        repeat (3) step();
        rst_neg = 1'b1;
        repeat (5) step();
        check("rst_ready", {31'd0, ready}, 32'd1);
        check("rst_done", {31'd0, done}, 32'd0);
        check("rst_up", {31'd0, but_up}, 32'd0);
        check("rst_down", {31'd0, but_down}, 32'd0);
        check("rst_count", {28'd0, cur_count}, 32'd0);
        check("rst_state", {30'd0, dbg_state}, {30'd0, ST_IDLE});

        // 0 -> 3 : three up presses
        issue(4'd3, 3 * PER, 3, 0, 4'd3, 1'b0, t);
        wait_done(1);
        // 3 -> 14 : diff 11, five down presses through the wrap
        issue(4'd14, 5 * PER, 0, 5, 4'd14, 1'b0, t);
        wait_done(2);
        // 14 -> 3 : diff 5, five up presses through the wrap
        issue(4'd3, 5 * PER, 5, 0, 4'd3, 1'b0, t);
        wait_done(3);
        // 3 -> 11 : diff 8 tie goes up; a start mid-sequence is ignored
        issue(4'd11, 8 * PER, 8, 0, 4'd11, 1'b0, t);
        while (cyc < t + 10) step();
        start = 1'b1;
        target = 4'd0;
        repeat (3) step();
        start = 1'b0;
        wait_done(4);
        // 11 -> 5 : diff 10, six down presses
        issue(4'd5, 6 * PER, 0, 6, 4'd5, 1'b0, t);
        wait_done(5);
        // 5 -> 5 : no presses, done the cycle after acceptance
        issue(4'd5, 0, 0, 0, 4'd5, 1'b0, t);
        wait_done(6);
        step();
        check("ready_after_zero", {31'd0, ready}, 32'd1);
        check("done_after_zero", {31'd0, done}, 32'd0);

        // reset in the second press cycle of 0 -> 2
        rst_neg = 1'b0;
        repeat (2) step();
        rst_neg = 1'b1;
        step();
        start = 1'b1;
        target = 4'd2;
        t = cyc + 1;
        step();
        start = 1'b0;
        while (cyc < t + 1) step();
        check("pre_reset_up", {31'd0, but_up}, 32'd1);
        rst_neg = 1'b0;
        #1;
        check("reset_up", {31'd0, but_up}, 32'd0);
        check("reset_down", {31'd0, but_down}, 32'd0);
        check("reset_count", {28'd0, cur_count}, 32'd0);
        check("reset_ready", {31'd0, ready}, 32'd1);
        repeat (2) step();
        rst_neg = 1'b1;
        repeat (2) step();

`ifdef BUTTON_SEQ_ABORT_EN
        // abort during the second press of 0 -> 6
        chk_len = 1'b0;
        issue(4'd6, PER + 1, 2, 0, 4'd2, 1'b1, t);
        while (cyc < t + PER) step();
        check("abort_pre_up", {31'd0, but_up}, 32'd1);
        abort = 1'b1;
        step();
        abort = 1'b0;
        check("abort_drop_up", {31'd0, but_up}, 32'd0);
        check("abort_done", {31'd0, done}, 32'd1);
        check("abort_flag", {31'd0, aborted}, 32'd1);
        wait_done(7);
        step();
        check("aborted_clears", {31'd0, aborted}, 32'd0);
`endif

        repeat (3) step();
        check("queue_empty", exp_q.size(), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/button_seq_driver.md
Name: button_seq_driver

Overview:
- Initiator end of the up/down push-button interface: emits clean press/release pulses on but_up/but_down to step a downstream up/down button counter to a requested target value.
- Keeps a shadow copy of the counter value and takes the shortest modular path.
- Used for automated setting of menu and selection counters (e.g. from a CPU register or a test controller) without physical buttons.

Parameters:
- N, 4, counter width; must match the downstream counter.
- HOLD_CYCLES, 4, cycles each button is held high; must be 1 or more.
- GAP_CYCLES, 4, low cycles after each release; must be 1 or more.
- TW, 8, internal timer width; 2^TW must be greater than max(HOLD_CYCLES, GAP_CYCLES).

Ports:
- clk  in  1  clock
- rst_neg  in  1  asynchronous active-low reset
- start  in  1  request; sampled only when ready=1
- target  in  N  requested counter value; latched on accepted start
- ready  out  1  high in IDLE only
- done  out  1  one-cycle pulse when sequence ends
- but_up  out  1  registered up-button drive
- but_down  out  1  registered down-button drive
- cur_count  out  N  shadow counter value

Behaviour:
- Reset (async, rst_neg low): state IDLE, but_up=0, but_down=0, done=0, ready=1, cur_count=0, timer=0, latched target=0. Reset mid-sequence drops both buttons in the same instant.
- All outputs are registered. but_up and but_down are never high simultaneously.
- States: IDLE, PRESS, GAP, DONE.
- IDLE:
  - start=1 latches target and computes diff = (target - cur_count) mod 2^N.
  - diff=0: go to DONE.
  - 0 < diff <= 2^(N-1): direction up. A tie at exactly 2^(N-1) goes up.
  - Otherwise: direction down.
  - Then go to PRESS.
- PRESS: the selected button is high for exactly HOLD_CYCLES cycles. On the final cycle, transition to GAP and, on the same edge, cur_count += 1 (up) or -= 1 (down), wrapping mod 2^N. This mirrors the downstream counter, which updates on release.
- GAP: both buttons low for exactly GAP_CYCLES cycles. On exit, go to DONE if cur_count == latched target, else back to PRESS.
- DONE: done=1 for one cycle, ready=0, then IDLE.
- start while not in IDLE is ignored. target changes after acceptance are ignored.
- Latency: start accepted at edge t, k presses needed → done high in cycle t + k*(HOLD_CYCLES+GAP_CYCLES) + 1. For k=0, done is high in cycle t+1.
- Maximum presses per request: 2^(N-1).

Optional Feature:
- Macro: BUTTON_SEQ_ABORT_EN.
- With the macro defined, add ports abort (in, 1) and aborted (out, 1).
  - abort=1 in PRESS: the button drops on the next edge, cur_count is updated (the release counts), and the state goes to DONE.
  - abort=1 in GAP: go to DONE.
  - aborted is high together with done only for aborted sequences; it is 0 at reset.
  - abort is ignored in IDLE and DONE.
- Without the macro: no abort or aborted ports, and sequences always run to completion.

Decomposition:
- Package button_seq_pkg holds:
  - state encoding localparams (IDLE, PRESS, GAP, DONE)
  - direction constants DIR_UP and DIR_DOWN
- One sub-module, button_seq_timer:
  - loadable TW-bit down-counter with a terminal-count flag
  - reused for HOLD and GAP timing

Test Plan:
- Parameters for all tests: N=4, HOLD=2, GAP=3. The downstream up/down button counter is instantiated and its output is checked alongside cur_count.
- Reset, then idle 5 cycles → ready=1, done=0, both buttons 0, cur_count=0.
- From 0, start with target=3 → 3 but_up pulses, each 2 high and 3 low, but_down stays 0; done in cycle t+16; cur_count=3; downstream counter=3.
- From 3, target=14 (diff=11) → 5 but_down pulses with wrap 0→15→14; cur_count=14; done at t+26.
- From 3, target=11 (diff=8, tie) → 8 but_up pulses; cur_count=11. Also assert start during the sequence with target=0 → ignored.
- From 5, target=5 → no pulses; done at t+1; ready returns at t+2.
- Reset asserted in the second PRESS cycle of a 0→2 sequence → buttons 0 immediately and cur_count=0.
- With BUTTON_SEQ_ABORT_EN: abort during the 2nd press of 0→6 → button drops the next cycle, cur_count=2, done=1 and aborted=1 together.
